// File: rtl/ur_muldiv_issue_pkg.sv
// Shared definitions for the mul/div issue stage.
// - op_e    : RV32M funct3 opcodes as carried on req_op_i
// - state_e : issue FSM states
// - DIV0_QUOT and div0_result(): results produced locally for a zero divisor
package ur_muldiv_issue_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  // Quotient of x/0 is all ones; remainder of x%0 is the dividend.
  function automatic logic [31:0] div0_result(input logic [2:0] op, input logic [31:0] ra);
    if (op == OP_REM || op == OP_REMU) return ra;
    return DIV0_QUOT;
  endfunction

endpackage

// File: rtl/ur_muldiv_issue.sv
// Issue/writeback sequencer for an external RV32M mul/div unit.
// Accepts one operation at a time, issues it as a one-cycle strobe with a
// one-hot opcode, waits for the unit's completion pulse (bounded by TIMEOUT),
// and presents the result on a valid/ready writeback port.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid_i/req_ready_o        request handshake
//   req_op_i, req_ra_i, req_rb_i, req_rd_i   funct3, operands, destination
//   flush_i                        kill the in-flight operation
//   md_valid_o, md_inst_*_o        issue strobe and one-hot opcode
//   md_ra_o, md_rb_o               registered operands
//   md_ready_i, md_result_i        completion pulse and result
//   wb_valid_o/wb_ready_i, wb_rd_o, wb_result_o   writeback
//   busy_o, timeout_o              not-idle flag, one-cycle timeout pulse
module ur_muldiv_issue
  import ur_muldiv_issue_pkg::*;
#(
  parameter bit          DIV0_BYPASS = 1'b1,
  parameter int unsigned TIMEOUT     = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_ra_i,
  input  logic [31:0] req_rb_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        md_valid_o,
  output logic        md_inst_mul_o,
  output logic        md_inst_mulh_o,
  output logic        md_inst_mulhsu_o,
  output logic        md_inst_mulhu_o,
  output logic        md_inst_div_o,
  output logic        md_inst_divu_o,
  output logic        md_inst_rem_o,
  output logic        md_inst_remu_o,
  output logic [31:0] md_ra_o,
  output logic [31:0] md_rb_o,
  input  logic        md_ready_i,
  input  logic [31:0] md_result_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_result_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e        state;
  logic [7:0]    md_inst;
  logic [4:0]    rd_q;
  logic          discard;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          bypass;

  assign req_ready_o = (state == ST_IDLE) && !flush_i;
  assign busy_o      = (state != ST_IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign bypass      = DIV0_BYPASS && req_op_i[2] && (req_rb_i == '0);

  assign md_inst_mul_o    = md_inst[0];
  assign md_inst_mulh_o   = md_inst[1];
  assign md_inst_mulhsu_o = md_inst[2];
  assign md_inst_mulhu_o  = md_inst[3];
  assign md_inst_div_o    = md_inst[4];
  assign md_inst_divu_o   = md_inst[5];
  assign md_inst_rem_o    = md_inst[6];
  assign md_inst_remu_o   = md_inst[7];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      md_valid_o  <= 1'b0;
      md_inst     <= '0;
      md_ra_o     <= '0;
      md_rb_o     <= '0;
      rd_q        <= '0;
      discard     <= 1'b0;
      cnt         <= '0;
      wb_valid_o  <= 1'b0;
      wb_rd_o     <= '0;
      wb_result_o <= '0;
      timeout_o   <= 1'b0;
    end else begin
      md_valid_o <= 1'b0;
      md_inst    <= '0;
      timeout_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            md_ra_o <= req_ra_i;
            md_rb_o <= req_rb_i;
            rd_q    <= req_rd_i;
            discard <= 1'b0;
            cnt     <= '0;
            if (bypass) begin
              wb_result_o <= div0_result(req_op_i, req_ra_i);
              // rd==0 has no architectural effect, so skip writeback entirely
              if (req_rd_i != '0) begin
                wb_rd_o    <= req_rd_i;
                wb_valid_o <= 1'b1;
                state      <= ST_WB;
              end
            end else begin
              md_valid_o <= 1'b1;
              md_inst    <= 8'b1 << req_op_i;
              state      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (flush_i) discard <= 1'b1;
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (flush_i) discard <= 1'b1;
          if (md_ready_i) begin
            // A flush arriving with the completion still kills the writeback
            if (discard || flush_i || rd_q == '0) begin
              state <= ST_IDLE;
            end else begin
              wb_result_o <= md_result_i;
              wb_rd_o     <= rd_q;
              wb_valid_o  <= 1'b1;
              state       <= ST_WB;
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            timeout_o <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WB: begin
          if (flush_i || wb_ready_i) begin
            wb_valid_o <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ur_muldiv_issue.sv
// Directed bench for ur_muldiv_issue. A behavioural mul/div unit answers each
// issue: multiply class completes in the third cycle after accept, divide
// class in the 35th, giving 4- and 36-cycle accept-to-writeback latencies.
module tb_ur_muldiv_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_op_i;
  logic [31:0] req_ra_i, req_rb_i;
  logic [4:0]  req_rd_i;
  logic        flush_i;
  logic        md_valid_o;
  logic        md_inst_mul_o, md_inst_mulh_o, md_inst_mulhsu_o, md_inst_mulhu_o;
  logic        md_inst_div_o, md_inst_divu_o, md_inst_rem_o, md_inst_remu_o;
  logic [31:0] md_ra_o, md_rb_o;
  logic        md_ready_i;
  logic [31:0] md_result_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_result_o;
  logic        busy_o, timeout_o;

  logic [7:0]  inst_vec;
  assign inst_vec = {md_inst_remu_o, md_inst_rem_o, md_inst_divu_o, md_inst_div_o,
                     md_inst_mulhu_o, md_inst_mulhsu_o, md_inst_mulh_o, md_inst_mul_o};

  ur_muldiv_issue #(.DIV0_BYPASS(1'b1), .TIMEOUT(48)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_ra_i(req_ra_i), .req_rb_i(req_rb_i), .req_rd_i(req_rd_i),
    .flush_i(flush_i),
    .md_valid_o(md_valid_o),
    .md_inst_mul_o(md_inst_mul_o), .md_inst_mulh_o(md_inst_mulh_o),
    .md_inst_mulhsu_o(md_inst_mulhsu_o), .md_inst_mulhu_o(md_inst_mulhu_o),
    .md_inst_div_o(md_inst_div_o), .md_inst_divu_o(md_inst_divu_o),
    .md_inst_rem_o(md_inst_rem_o), .md_inst_remu_o(md_inst_remu_o),
    .md_ra_o(md_ra_o), .md_rb_o(md_rb_o),
    .md_ready_i(md_ready_i), .md_result_i(md_result_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_result_o(wb_result_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int mv_cnt = 0;  // cycles with md_valid_o high
  int wb_cnt = 0;  // cycles with wb_valid_o high
  bit unit_en = 1'b1;

  always @(negedge clk) begin
    if (md_valid_o) mv_cnt++;
    if (wb_valid_o) wb_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_md(input logic [7:0] inst, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = '0;
    if (inst[0]) p = {32'b0, a} * {32'b0, b};
    if (inst[1]) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    if (inst[2]) p = {{32{a[31]}}, a} * {32'b0, b};
    if (inst[3]) p = {32'b0, a} * {32'b0, b};
    if (inst[0]) return p[31:0];
    if (|inst[3:1]) return p[63:32];
    if (inst[4]) return (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a
                        : 32'($signed(a) / $signed(b));
    if (inst[5]) return (b == 0) ? 32'hFFFF_FFFF : a / b;
    if (inst[6]) return (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0
                        : 32'($signed(a) % $signed(b));
    return (b == 0) ? a : a % b;
  endfunction

  // Behavioural mul/div unit; drops its pending answer if reset is seen.
  initial begin
    logic [31:0] res;
    int          d;
    bit          ab;
    md_ready_i  = 1'b0;
    md_result_i = '0;
    forever begin
      @(posedge clk); #1;
      if (md_valid_o && unit_en) begin
        res = ref_md(inst_vec, md_ra_o, md_rb_o);
        d   = (|inst_vec[7:4]) ? 34 : 2;
        ab  = 1'b0;
        for (int i = 0; i < d; i++) begin
          @(posedge clk);
          if (!rst_n) ab = 1'b1;
        end
        #1;
        if (!ab) begin
          md_ready_i  = 1'b1;
          md_result_i = res;
          @(posedge clk); #1;
          md_ready_i  = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Returns one cycle after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [31:0] ra, input logic [31:0] rb, input logic [4:0] rd);
    int n = 0;
    while (!req_ready_o && n < 100) begin step(); n++; end
    if (n >= 100) check("req_ready_wait", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_op_i = op; req_ra_i = ra; req_rb_i = rb; req_rd_i = rd;
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_wb(output int lat);
    lat = 1;
    while (!wb_valid_o && lat < 200) begin step(); lat++; end
  endtask

  initial begin
    int lat, mv0, wb0, n;
    logic [31:0] held;
    rst_n = 1'b0; req_valid_i = 1'b0; req_op_i = '0; req_ra_i = '0; req_rb_i = '0;
    req_rd_i = '0; flush_i = 1'b0; wb_ready_i = 1'b1;
    repeat (3) step();
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_md_valid", 32'(md_valid_o), 32'd0);
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    check("rst_wb_result", wb_result_o, 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_req_ready", 32'(req_ready_o), 32'd1);

    // MUL 7*6 -> 42 to x5
    mv0 = mv_cnt;
    send(3'd0, 32'd7, 32'd6, 5'd5);
    check("mul_md_valid", 32'(md_valid_o), 32'd1);
    check("mul_inst_onehot", {24'b0, inst_vec}, 32'h01);
    check("mul_md_ra", md_ra_o, 32'd7);
    wait_wb(lat);
    check("mul_lat", 32'(lat), 32'd4);
    check("mul_rd", {27'b0, wb_rd_o}, 32'd5);
    check("mul_res", wb_result_o, 32'd42);
    check("mul_md_valid_cycles", 32'(mv_cnt - mv0), 32'd1);

    // DIVU 100/7 -> 14
    send(3'd5, 32'd100, 32'd7, 5'd3);
    check("divu_inst", {24'b0, inst_vec}, 32'h20);
    wait_wb(lat);
    check("divu_lat", 32'(lat), 32'd36);
    check("divu_res", wb_result_o, 32'd14);

    // REM -7 % 2 -> -1
    send(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7);
    wait_wb(lat);
    check("rem_lat", 32'(lat), 32'd36);
    check("rem_res", wb_result_o, 32'hFFFF_FFFF);

    // Divide by zero bypass
    mv0 = mv_cnt;
    send(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd8);
    wait_wb(lat);
    check("div0_lat", 32'(lat), 32'd1);
    check("div0_res", wb_result_o, 32'hFFFF_FFFF);
    check("div0_rd", {27'b0, wb_rd_o}, 32'd8);
    send(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd9);
    wait_wb(lat);
    check("rem0_lat", 32'(lat), 32'd1);
    check("rem0_res", wb_result_o, 32'hFFFF_FFF9);
    step();
    check("div0_no_issue", 32'(mv_cnt - mv0), 32'd0);

    // Flush in WAIT cycle 10 of a DIVU
    wb0 = wb_cnt;
    send(3'd5, 32'd100, 32'd7, 5'd4);
    repeat (10) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    n = 0;
    while (!md_ready_i && n < 60) begin step(); n++; end
    check("flush_ready_seen", 32'(md_ready_i), 32'd1);
    check("flush_busy_at_ready", 32'(busy_o), 32'd1);
    step();
    check("flush_busy_after", 32'(busy_o), 32'd0);
    check("flush_no_wb", 32'(wb_cnt - wb0), 32'd0);
    send(3'd0, 32'd3, 32'd5, 5'd1);
    wait_wb(lat);
    check("after_flush_lat", 32'(lat), 32'd4);
    check("after_flush_res", wb_result_o, 32'd15);

    // Completion and flush in the same WAIT cycle
    step();
    wb0 = wb_cnt;
    send(3'd5, 32'd50, 32'd5, 5'd2);
    n = 0;
    while (!md_ready_i && n < 60) begin step(); n++; end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("race_busy", 32'(busy_o), 32'd0);
    repeat (3) step();
    check("race_no_wb", 32'(wb_cnt - wb0), 32'd0);

    // MULHU with writeback stalled
    wb_ready_i = 1'b0;
    send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
    wait_wb(lat);
    check("mulhu_lat", 32'(lat), 32'd4);
    held = wb_result_o;
    check("mulhu_res", held, 32'hFFFF_FFFE);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_wb_valid", 32'(wb_valid_o), 32'd1);
      check("stall_wb_result", wb_result_o, 32'hFFFF_FFFE);
      check("stall_req_ready", 32'(req_ready_o), 32'd0);
    end
    wb_ready_i = 1'b1;
    step();
    check("stall_release_wb", 32'(wb_valid_o), 32'd0);
    check("stall_release_ready", 32'(req_ready_o), 32'd1);

    // rd == 0 skips writeback
    wb0 = wb_cnt;
    send(3'd0, 32'd2, 32'd3, 5'd0);
    repeat (6) step();
    check("rd0_no_wb", 32'(wb_cnt - wb0), 32'd0);
    check("rd0_idle", 32'(busy_o), 32'd0);

    // Timeout with the unit silent
    unit_en = 1'b0;
    send(3'd0, 32'd1, 32'd1, 5'd6);
    n = 1;
    while (!timeout_o && n < 100) begin step(); n++; end
    check("timeout_cycle", 32'(n), 32'd50);
    check("timeout_busy", 32'(busy_o), 32'd0);
    step();
    check("timeout_pulse_end", 32'(timeout_o), 32'd0);
    unit_en = 1'b1;

    // Reset mid-WAIT
    wb0 = wb_cnt;
    send(3'd5, 32'd100, 32'd7, 5'd11);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_wb_result", wb_result_o, 32'd0);
    check("midrst_md_ra", md_ra_o, 32'd0);
    check("midrst_wb_rd", {27'b0, wb_rd_o}, 32'd0);
    rst_n = 1'b1;
    repeat (40) step();
    check("midrst_no_wb", 32'(wb_cnt - wb0), 32'd0);
    check("midrst_idle", 32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
